// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache memory responder: store-size
// bit positions, the responder FSM state type and line/beat geometry helpers.
package cache_pkg;

  localparam int BYTE_LANES = 8;

  // Bit positions inside req_store_type_i.
  localparam int ST_B1 = 0;
  localparam int ST_H  = 1;
  localparam int ST_W  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int beat_idx_w(input int line_beats);
    return $clog2(line_beats);
  endfunction

  function automatic int line_off_w(input int line_beats);
    return 32'sd3 + $clog2(line_beats);
  endfunction

  // Byte 0 is always written; the size bits enable the higher byte groups.
  function automatic logic [7:0] store_byte_mask(input logic [2:0] st);
    return {{4{st[ST_W]}}, {2{st[ST_H]}}, st[ST_B1], 1'b1};
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache <-> memory responder bus: request channel (refill/store) and the
// refill response beat channel plus the store acknowledge.
interface cache_mem_responder_if
  import cache_pkg::*;
#(
  parameter int LINE_BEATS = 4
);
  localparam int BW = beat_idx_w(LINE_BEATS);

  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [31:0]   req_addr_i;
  logic [2:0]    req_store_type_i;
  logic [63:0]   req_data_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [63:0]   rsp_data_o;
  logic [BW-1:0] rsp_beat_o;
  logic          rsp_last_o;
  logic          wr_ack_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_store_type_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_beat_o, rsp_last_o, wr_ack_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_store_type_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_beat_o, rsp_last_o, wr_ack_o
  );

endinterface

// File: rtl/cache_byte_lane_ram.sv
// One byte lane of the backing store: single write port plus a synchronous
// read port whose output register holds while re_i is low.
module cache_byte_lane_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; holding rdata_q keeps a stalled beat stable.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the data cache: critical-word-first wrapping line
// refills and byte-granular write-through stores into a byte-laned RAM.
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int MEM_BYTES  = 8192,
  parameter int WORD_WID   = 64,
  parameter int LINE_BEATS = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  cache_mem_responder_if.slave  bus
);

  localparam int AW   = $clog2(MEM_BYTES);
  localparam int RW   = AW - 3;
  localparam int ROWS = MEM_BYTES / BYTE_LANES;
  localparam int BW   = beat_idx_w(LINE_BEATS);
  localparam int LOW  = line_off_w(LINE_BEATS);

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [RW-1:0] line_row_q, line_row_d;
  logic          wr_ack_q, wr_ack_d;

  logic [AW-1:0]       addr_s;
  logic                unused_addr_s;
  logic [RW-1:0]       row_base_s;
  logic [2:0]          lane_off_s;
  logic [BW-1:0]       start_beat_s;
  logic [RW-1:0]       line_row_s;
  logic [7:0]          byte_mask_s;
  logic                req_fire_s;
  logic                rsp_fire_s;
  logic                st_fire_s;
  logic                rd_en_s;
  logic [RW-1:0]       rd_row_s;
  logic [WORD_WID-1:0] rd_data_s;

  assign addr_s        = bus.req_addr_i[AW-1:0];
  assign unused_addr_s = ^bus.req_addr_i[31:AW];
  assign row_base_s    = addr_s[AW-1:3];
  assign lane_off_s    = addr_s[2:0];
  assign start_beat_s  = addr_s[LOW-1:3];
  assign line_row_s    = row_base_s & ~RW'(LINE_BEATS - 1);
  assign byte_mask_s   = store_byte_mask(bus.req_store_type_i);
  assign req_fire_s    = bus.req_valid_i & ready_q;
  assign rsp_fire_s    = rsp_valid_q & bus.rsp_ready_i;
  assign st_fire_s     = req_fire_s & bus.req_we_i;

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      beat_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      line_row_q  <= '0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      line_row_q  <= line_row_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  // Next state; each accepted beat pre-fetches the following word so it is
  // visible one cycle later, and a stalled beat issues no read at all.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    line_row_d  = line_row_q;
    wr_ack_d    = 1'b0;
    rd_en_s     = 1'b0;
    rd_row_s    = line_row_q;
    case (state_q)
      IDLE: begin
        if (req_fire_s && !bus.req_we_i) begin
          state_d     = BURST;
          ready_d     = 1'b0;
          rsp_valid_d = 1'b1;
          beat_d      = start_beat_s;
          cnt_d       = '0;
          last_d      = 1'b0;
          line_row_d  = line_row_s;
          rd_en_s     = 1'b1;
          rd_row_s    = line_row_s | RW'(start_beat_s);
        end else begin
          wr_ack_d = st_fire_s;
        end
      end
      BURST: begin
        if (rsp_fire_s && last_q) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b0;
          last_d      = 1'b0;
          beat_d      = '0;
        end else if (rsp_fire_s) begin
          beat_d   = beat_q + BW'(1);
          cnt_d    = cnt_q + BW'(1);
          last_d   = (cnt_q == BW'(LINE_BEATS - 2));
          rd_en_s  = 1'b1;
          rd_row_s = line_row_q | RW'(beat_d);
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b0;
        last_d      = 1'b0;
      end
    endcase
  end

  // Lane g stores store byte n = (g - addr[2:0]) mod 8; lanes below the start
  // offset belong to the next row, which is how word-crossing stores work.
  for (genvar g = 0; g < BYTE_LANES; g++) begin : g_lane
    logic [2:0]    n_s;
    logic [RW-1:0] wrow_s;
    logic [7:0]    wdata_s;
    logic          we_s;
    logic [7:0]    rdata_s;

    assign n_s     = 3'(g) - lane_off_s;
    assign wrow_s  = (3'(g) >= lane_off_s) ? row_base_s : row_base_s + RW'(1);
    assign wdata_s = bus.req_data_i[{n_s, 3'b000} +: 8];
    assign we_s    = st_fire_s & byte_mask_s[n_s];

    cache_byte_lane_ram #(.DEPTH(ROWS)) u_ram (
      .clk_i   (clk_i),
      .we_i    (we_s),
      .waddr_i (wrow_s),
      .wdata_i (wdata_s),
      .re_i    (rd_en_s),
      .raddr_i (rd_row_s),
      .rdata_o (rdata_s)
    );

    assign rd_data_s[8*g +: 8] = rdata_s;
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rd_data_s;
  assign bus.rsp_beat_o  = beat_q;
  assign bus.rsp_last_o  = last_q;
  assign bus.wr_ack_o    = wr_ack_q;

endmodule
